// File: rtl/ntt_out_pkg.sv
// Shared types and constants for the NTT output collector: FSM encoding,
// frame geometry and the final conditional subtraction mod q.
package ntt_out_pkg;

  localparam int DEF_PE_DEPTH  = 5;
  localparam int DEF_MAX_DEPTH = 10;
  localparam int DEF_WORD_W    = 32;
  localparam int DEF_COEF_W    = 16;

  localparam int BURST_LEN = 1 << (DEF_PE_DEPTH + 1);
  localparam int MAX_N     = 1 << DEF_MAX_DEPTH;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_GAP     = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  // Inputs are < 2q, so a single subtraction fully reduces; the extra bit is the borrow.
  function automatic logic [DEF_COEF_W-1:0] cond_sub(input logic [DEF_COEF_W-1:0] c,
                                                     input logic [DEF_COEF_W-1:0] q);
    logic [DEF_COEF_W:0] diff;
    diff = {1'b0, c} - {1'b0, q};
    return diff[DEF_COEF_W] ? c : diff[DEF_COEF_W-1:0];
  endfunction

endpackage

// File: rtl/ntt_out_collector_if.sv
// Output coefficient stream of the NTT output collector.
interface ntt_out_collector_if #(
  parameter int COEF_W    = ntt_out_pkg::DEF_COEF_W,
  parameter int MAX_DEPTH = ntt_out_pkg::DEF_MAX_DEPTH
);
  // A word transfers on a cycle where out_valid && out_ready. Once out_valid is
  // raised, out_data/out_index/out_last stay stable until that transfer happens,
  // and out_valid never drops without one. out_last marks the final index N-1.
  logic                 out_valid;
  logic                 out_ready;
  logic [COEF_W-1:0]    out_data;
  logic [MAX_DEPTH-1:0] out_index;
  logic                 out_last;

  modport master (output out_valid, out_data, out_index, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_index, out_last, output out_ready);

endinterface

// File: rtl/ntt_coef_ram.sv
// Simple dual-port coefficient buffer: one write port, one registered read port.
module ntt_coef_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read data only moves on re, so a stalled consumer sees a stable word.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ntt_out_collector.sv
// Captures the burst-interleaved NTT result, reduces mod q, stores it in
// natural order and replays it on a valid/ready stream.
module ntt_out_collector
  import ntt_out_pkg::*;
#(
  parameter int PE_DEPTH  = DEF_PE_DEPTH,
  parameter int MAX_DEPTH = DEF_MAX_DEPTH,
  parameter int WORD_W    = DEF_WORD_W,
  parameter int COEF_W    = DEF_COEF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              done,
  input  logic [WORD_W-1:0] din,
  input  logic [11:0]       ring_size,
  input  logic [COEF_W-1:0] q,
  output logic              busy,
  output logic              err,
  output state_t            dbg_state,
  ntt_out_collector_if.master out_s
);

  localparam int BW    = PE_DEPTH + 1;
  localparam int NW    = MAX_DEPTH + 1;
  localparam int N_MAX = 1 << MAX_DEPTH;
  localparam logic [11:0] MIN_SIZE = 12'(1 << BW);
  localparam logic [11:0] MAX_SIZE = 12'(N_MAX);

  state_t               state, state_nxt;
  logic                 done_q, done_rise, size_ok;
  logic [NW-1:0]        n_reg, nb, burst_cnt, rd_cnt;
  logic [COEF_W-1:0]    q_reg, wr_data, rd_data;
  logic [MAX_DEPTH-1:0] m, n_half, wr_addr;
  logic [BW-1:0]        w_cnt;
  logic                 wr_en, rd_en, xfer, last_word, bursts_done, rd_more;
  logic                 out_valid_r, out_last_r;
  logic [MAX_DEPTH-1:0] out_index_r;
  logic                 unused_hi;

  assign unused_hi   = ^din[WORD_W-1:COEF_W];
  assign done_rise   = done && !done_q;
  assign size_ok     = (ring_size != 12'd0) && ((ring_size & (ring_size - 12'd1)) == 12'd0)
                    && (ring_size >= MIN_SIZE) && (ring_size <= MAX_SIZE);
  assign last_word   = &w_cnt;
  assign nb          = n_reg >> BW;
  assign bursts_done = (burst_cnt == nb);
  assign n_half      = n_reg[MAX_DEPTH:1];
  // Even words fill the lower half in order, odd words the upper half.
  assign wr_addr     = m[0] ? ({1'b0, m[MAX_DEPTH-1:1]} + n_half) : {1'b0, m[MAX_DEPTH-1:1]};
  assign wr_data     = cond_sub(din[COEF_W-1:0], q_reg);
  assign rd_more     = (rd_cnt != n_reg);
  assign xfer        = out_valid_r && out_s.out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (done_rise && size_ok) state_nxt = ST_CAPTURE;
      ST_CAPTURE: if (last_word) state_nxt = ST_GAP;
      ST_GAP:     state_nxt = bursts_done ? ST_DRAIN : ST_CAPTURE;
      ST_DRAIN:   if (xfer && out_last_r) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Outputs and strobes; a new read issues in the same cycle as a transfer.
  always_comb begin
    busy      = (state != ST_IDLE);
    wr_en     = (state == ST_CAPTURE);
    rd_en     = (state == ST_DRAIN) && rd_more && (!out_valid_r || out_s.out_ready);
    dbg_state = state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q      <= 1'b0;
      err         <= 1'b0;
      n_reg       <= '0;
      q_reg       <= '0;
      m           <= '0;
      w_cnt       <= '0;
      burst_cnt   <= '0;
      rd_cnt      <= '0;
      out_valid_r <= 1'b0;
      out_index_r <= '0;
      out_last_r  <= 1'b0;
    end else begin
      done_q <= done;
      if (done_rise && ((state != ST_IDLE) || !size_ok)) err <= 1'b1;
      if ((state == ST_IDLE) && done_rise) begin
        n_reg     <= ring_size[MAX_DEPTH:0];
        q_reg     <= q;
        m         <= '0;
        w_cnt     <= '0;
        burst_cnt <= '0;
        rd_cnt    <= '0;
      end
      if (wr_en) begin
        m     <= m + MAX_DEPTH'(1);
        w_cnt <= w_cnt + BW'(1);
        if (last_word) burst_cnt <= burst_cnt + NW'(1);
      end
      if (rd_en) begin
        out_valid_r <= 1'b1;
        out_index_r <= rd_cnt[MAX_DEPTH-1:0];
        out_last_r  <= (rd_cnt == n_reg - NW'(1));
        rd_cnt      <= rd_cnt + NW'(1);
      end else if (xfer) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  ntt_coef_ram #(
    .DEPTH (N_MAX),
    .AW    (MAX_DEPTH),
    .DW    (COEF_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr (rd_cnt[MAX_DEPTH-1:0]),
    .rdata (rd_data)
  );

  // The RAM output has no reset, so data is forced to zero whenever nothing is offered.
  assign out_s.out_valid = out_valid_r;
  assign out_s.out_data  = out_valid_r ? rd_data : '0;
  assign out_s.out_index = out_index_r;
  assign out_s.out_last  = out_last_r;

endmodule

// File: tb/tb_ntt_out_collector.sv
// Directed bench for ntt_out_collector with a scoreboard on the output stream.
module tb_ntt_out_collector;
  import ntt_out_pkg::*;

  localparam int B     = BURST_LEN;
  localparam int EXP_W = 1 + DEF_MAX_DEPTH + DEF_COEF_W;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        done = 1'b0;
  logic [31:0] din = '0;
  logic [11:0] ring_size = '0;
  logic [15:0] q = '0;
  logic        busy, err;
  state_t      dbg_state;

  ntt_out_collector_if #(.COEF_W(DEF_COEF_W), .MAX_DEPTH(DEF_MAX_DEPTH)) out_s ();

  ntt_out_collector dut (
    .clk       (clk),
    .reset     (reset),
    .done      (done),
    .din       (din),
    .ring_size (ring_size),
    .q         (q),
    .busy      (busy),
    .err       (err),
    .dbg_state (dbg_state),
    .out_s     (out_s)
  );

  int total = 0;
  int bad = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [31:0] words [1024];
  bit rand_ready = 1'b0;
  bit seen_valid = 1'b0;
  int first_valid_cyc = 0;
  int t_cyc = 0;
  int valid_cnt = 0;

  function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  // Consumer ready driver
  initial begin
    out_s.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_s.out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Scoreboard / stream monitor
  initial begin
    logic [EXP_W:0]   prev_word;
    logic [EXP_W-1:0] cur, exp_w;
    bit               prev_stall;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      cur = {out_s.out_last, out_s.out_index, out_s.out_data};
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) check("stall_hold", 32'({out_s.out_valid, cur}), 32'(prev_word));
        if (out_s.out_valid) begin
          valid_cnt++;
          if (!seen_valid) begin
            seen_valid = 1'b1;
            first_valid_cyc = cyc;
          end
        end
        if (out_s.out_valid && out_s.out_ready) begin
          check("sb_avail", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            check("sb_word", 32'(cur), 32'(exp_w));
          end
        end
        prev_stall = out_s.out_valid && !out_s.out_ready;
        prev_word  = {1'b1, cur};
      end
    end
  end

  // Driver: one frame of n words starting with a done edge; only n_words are fed.
  task automatic drive_frame(input int n, input int qv, input bit hold, input int n_words,
                             input bit expect_out);
    logic [15:0] expv [1024];
    int cv, idx;
    if (expect_out) begin
      for (int mm = 0; mm < n; mm++) begin
        cv  = int'(words[mm][15:0]);
        idx = (mm % 2 == 0) ? (mm / 2) : (mm / 2 + n / 2);
        expv[idx] = 16'((cv >= qv) ? (cv - qv) : cv);
      end
      for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), 10'(i), expv[i]});
    end
    @(posedge clk);
    #1;
    ring_size  = 12'(n);
    q          = 16'(qv);
    done       = 1'b1;
    t_cyc      = cyc;
    seen_valid = 1'b0;
    for (int k = 0; k < n_words; k++) begin
      @(posedge clk);
      #1;
      if (!hold) done = 1'b0;
      din = words[k];
      if (k == 0) check("busy_capture", 32'(busy), 32'd1);
      if (k % B == B - 1) begin
        @(posedge clk);
        #1;
        din = 32'hDEAD_BEEF;
      end
    end
  endtask

  task automatic wait_drain(input string tag);
    int cnt;
    cnt = 0;
    while ((exp_q.size() != 0 || busy) && cnt < 20000) begin
      @(negedge clk);
      cnt++;
    end
    check(tag, 32'(exp_q.size() == 0 && !busy), 32'd1);
  endtask

  task automatic fill_random(input int n, input int qv);
    for (int i = 0; i < n; i++)
      words[i] = {16'($urandom), 16'($urandom_range(0, 2 * qv - 1))};
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int cnt;
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_s.out_valid), 32'd0);
    check("rst_data",  32'(out_s.out_data),  32'd0);
    check("rst_index", 32'(out_s.out_index), 32'd0);
    check("rst_last",  32'(out_s.out_last),  32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_err",   32'(err),  32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;

    // N=256, word m carries m
    for (int i = 0; i < 256; i++) words[i] = 32'(i);
    drive_frame(256, 7681, 1'b0, 256, 1'b1);
    wait_drain("drain_ramp");
    check("latency_ramp", 32'(first_valid_cyc - t_cyc), 32'(4 * (B + 1) + 2));
    check("err_ramp", 32'(err), 32'd0);

    // Reduction corner values, noisy upper bits
    fill_random(256, 7681);
    words[0] = {16'hA5A5, 16'd0};
    words[1] = {16'h1234, 16'd7680};
    words[2] = {16'hFFFF, 16'd7681};
    words[3] = {16'h0F0F, 16'd15361};
    drive_frame(256, 7681, 1'b0, 256, 1'b1);
    wait_drain("drain_reduce");

    // Backpressure
    rand_ready = 1'b1;
    fill_random(256, 7681);
    drive_frame(256, 7681, 1'b0, 256, 1'b1);
    wait_drain("drain_backpressure");
    check("latency_bp", 32'(first_valid_cyc - t_cyc), 32'(4 * (B + 1) + 2));

    // Reset mid burst 2, then a fresh frame
    fill_random(256, 7681);
    drive_frame(256, 7681, 1'b0, 2 * B + 10, 1'b0);
    check("pre_abort_state", 32'(dbg_state), 32'(ST_CAPTURE));
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy",  32'(busy), 32'd0);
    check("abort_valid", 32'(out_s.out_valid), 32'd0);
    check("abort_data",  32'(out_s.out_data),  32'd0);
    check("abort_index", 32'(out_s.out_index), 32'd0);
    check("abort_last",  32'(out_s.out_last),  32'd0);
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    fill_random(256, 7681);
    drive_frame(256, 7681, 1'b0, 256, 1'b1);
    wait_drain("drain_after_abort");
    rand_ready = 1'b0;

    // Overrun: second done edge during DRAIN
    fill_random(256, 3329);
    drive_frame(256, 3329, 1'b0, 256, 1'b1);
    cnt = 0;
    while (dbg_state != ST_DRAIN && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    check("reach_drain", 32'(dbg_state), 32'(ST_DRAIN));
    @(posedge clk);
    #1;
    done = 1'b1;
    @(posedge clk);
    #1;
    done = 1'b0;
    check("overrun_err", 32'(err), 32'd1);
    wait_drain("drain_overrun");
    check("overrun_err_sticky", 32'(err), 32'd1);
    pulse_reset();
    check("err_cleared", 32'(err), 32'd0);

    // N=1024 with done held high across the frame
    fill_random(1024, 12289);
    drive_frame(1024, 12289, 1'b1, 1024, 1'b1);
    wait_drain("drain_1024");
    done = 1'b0;
    check("latency_1024", 32'(first_valid_cyc - t_cyc), 32'(16 * (B + 1) + 2));
    check("err_held_done", 32'(err), 32'd0);

    // Bad ring size
    valid_cnt = 0;
    @(posedge clk);
    #1;
    ring_size = 12'd200;
    done = 1'b1;
    @(posedge clk);
    #1;
    done = 1'b0;
    check("bad_size_err", 32'(err), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    check("bad_size_state", 32'(dbg_state), 32'(ST_IDLE));
    check("bad_size_busy", 32'(busy), 32'd0);
    check("bad_size_no_valid", 32'(valid_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
